// File: rtl/axis_fwft_packet_fifo.sv
// +--------------------------------------------------------------------------+
// | axis_fwft_packet_fifo                                                    |
// | First-word-fall-through FIFO that stores {tuser, tlast, tdata} per beat. |
// | AXIS_FWFT_FIFO_PACKET_MODE_EN: release words only once a packet is whole.|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module axis_fwft_packet_fifo #(
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int FIFO_DATA_WIDTH = AXIS_DATA_WIDTH + 2,
  parameter int DEPTH_BITS      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_axis_tuser,
  input  logic [AXIS_DATA_WIDTH-1:0] i_axis_tdata,
  input  logic                       i_axis_tlast,
  input  logic                       i_axis_tvalid,
  output logic                       o_axis_tready,
  output logic [FIFO_DATA_WIDTH-1:0] o_fifo_data,
  input  logic                       i_fifo_r_stb,
  output logic                       o_fifo_empty,
  output logic                       o_fifo_not_empty,
  output logic [DEPTH_BITS:0]        o_fifo_count,
  output logic                       o_overflow
);

  localparam int                  c_depth = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] c_full  = (DEPTH_BITS + 1)'(c_depth);
  localparam logic [DEPTH_BITS:0] c_one   = (DEPTH_BITS + 1)'(1);

  logic [FIFO_DATA_WIDTH-1:0] mem_q [c_depth];

  logic [DEPTH_BITS:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_BITS:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_BITS:0] count_q, count_d;
  logic                tready_q, tready_d;
  logic                not_empty_q, not_empty_d;
  logic                overflow_q, overflow_d;

  logic                       w_wr_en;
  logic                       w_rd_en;
  logic [FIFO_DATA_WIDTH-1:0] w_head;

  assign w_wr_en = i_axis_tvalid & tready_q;
  assign w_rd_en = i_fifo_r_stb & not_empty_q;
  assign w_head  = mem_q[rd_ptr_q[DEPTH_BITS-1:0]];

  // Storage is deliberately left out of reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      mem_q[wr_ptr_q[DEPTH_BITS-1:0]] <= {i_axis_tuser, i_axis_tlast, i_axis_tdata};
    end
  end

`ifdef AXIS_FWFT_FIFO_PACKET_MODE_EN
  logic [DEPTH_BITS:0] pkt_count_q, pkt_count_d;
  logic                w_wr_last;
  logic                w_rd_last;

  assign w_wr_last = w_wr_en & i_axis_tlast;
  assign w_rd_last = w_rd_en & w_head[FIFO_DATA_WIDTH-2];

  always_comb begin
    pkt_count_d = pkt_count_q;
    case ({w_wr_last, w_rd_last})
      2'b10:   pkt_count_d = pkt_count_q + c_one;
      2'b01:   pkt_count_d = pkt_count_q - c_one;
      default: pkt_count_d = pkt_count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_count_q <= '0;
    end else begin
      pkt_count_q <= pkt_count_d;
    end
  end
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_wr_en) begin
      wr_ptr_d = wr_ptr_q + c_one;
    end
    if (w_rd_en) begin
      rd_ptr_d = rd_ptr_q + c_one;
    end
    case ({w_wr_en, w_rd_en})
      2'b10:   count_d = count_q + c_one;
      2'b01:   count_d = count_q - c_one;
      default: count_d = count_q;
    endcase
    tready_d   = (count_d != c_full);
    overflow_d = overflow_q | (i_axis_tvalid & ~tready_q);
`ifdef AXIS_FWFT_FIFO_PACKET_MODE_EN
    // A full FIFO holding no tlast can never complete its packet, so let it drain.
    not_empty_d = ((count_d != '0) && (pkt_count_d != '0)) ||
                  ((count_d == c_full) && (pkt_count_d == '0));
`else
    not_empty_d = (count_d != '0);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      tready_q    <= 1'b0;
      not_empty_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      tready_q    <= tready_d;
      not_empty_q <= not_empty_d;
      overflow_q  <= overflow_d;
    end
  end

  assign o_axis_tready    = tready_q;
  assign o_fifo_data      = w_head;
  assign o_fifo_not_empty = not_empty_q;
  assign o_fifo_empty     = ~not_empty_q;
  assign o_fifo_count     = count_q;
  assign o_overflow       = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_axis_fwft_packet_fifo.sv
// +--------------------------------------------------------------------------+
// | tb_axis_fwft_packet_fifo                                                 |
// | Self-checking bench: queue of expected head words plus direct flag checks.|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_axis_fwft_packet_fifo;

  logic        clk;
  logic        rst;
  logic        i_axis_tuser;
  logic [31:0] i_axis_tdata;
  logic        i_axis_tlast;
  logic        i_axis_tvalid;
  logic        o_axis_tready;
  logic [33:0] o_fifo_data;
  logic        i_fifo_r_stb;
  logic        o_fifo_empty;
  logic        o_fifo_not_empty;
  logic [4:0]  o_fifo_count;
  logic        o_overflow;

  int          tests;
  int          fails;
  logic [33:0] exp_q [$];
  logic [33:0] exp_word;

  axis_fwft_packet_fifo dut (
    .clk              (clk),
    .rst              (rst),
    .i_axis_tuser     (i_axis_tuser),
    .i_axis_tdata     (i_axis_tdata),
    .i_axis_tlast     (i_axis_tlast),
    .i_axis_tvalid    (i_axis_tvalid),
    .o_axis_tready    (o_axis_tready),
    .o_fifo_data      (o_fifo_data),
    .i_fifo_r_stb     (i_fifo_r_stb),
    .o_fifo_empty     (o_fifo_empty),
    .o_fifo_not_empty (o_fifo_not_empty),
    .o_fifo_count     (o_fifo_count),
    .o_overflow       (o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Every read the DUT will perform at the next edge must pop the oldest expected word.
  always @(negedge clk) begin
    if (rst && i_fifo_r_stb && o_fifo_not_empty) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL head_unexpected: got 0x%0h, expected no readable word", o_fifo_data);
      end else begin
        exp_word = exp_q.pop_front();
        chk("head_word", {30'd0, o_fifo_data}, {30'd0, exp_word});
      end
    end
  end

  // One clock cycle of stimulus; returns 1 time unit after the active edge.
  task automatic cyc(input logic v, input logic [31:0] d, input logic last,
                     input logic user, input logic rs);
    i_axis_tvalid = v;
    i_axis_tdata  = d;
    i_axis_tlast  = last;
    i_axis_tuser  = user;
    i_fifo_r_stb  = rs;
    @(negedge clk);
    if (v && o_axis_tready) exp_q.push_back({user, last, d});
    @(posedge clk);
    #1;
    i_axis_tvalid = 1'b0;
    i_fifo_r_stb  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b0;
    i_axis_tvalid = 1'b0;
    i_axis_tdata  = '0;
    i_axis_tlast  = 1'b0;
    i_axis_tuser  = 1'b0;
    i_fifo_r_stb  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_count", 64'(o_fifo_count), 64'd0);
    chk("rst_empty", 64'(o_fifo_empty), 64'd1);
    chk("rst_not_empty", 64'(o_fifo_not_empty), 64'd0);
    chk("rst_overflow", 64'(o_overflow), 64'd0);
    chk("rst_tready", 64'(o_axis_tready), 64'd0);
    rst = 1'b1;
    idle(2);
    chk("tready_after_rst", 64'(o_axis_tready), 64'd1);

    // Three beats, head visible one cycle after the first write.
    cyc(1'b1, 32'hA0, 1'b0, 1'b0, 1'b0);
    chk("first_not_empty", 64'(o_fifo_not_empty), 64'd1);
    chk("first_head", 64'(o_fifo_data), 64'h0_0000_00A0);
    cyc(1'b1, 32'hA1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'hA2, 1'b1, 1'b0, 1'b0);
    chk("count_3", 64'(o_fifo_count), 64'd3);
    drain(3);
    chk("count_drained", 64'(o_fifo_count), 64'd0);
    chk("empty_drained", 64'(o_fifo_empty), 64'd1);

    // Fill to full, overflow attempt, one read from full.
    for (int i = 0; i < 16; i++)
      cyc(1'b1, 32'h100 + 32'(i), (i == 15), i[0], 1'b0);
    chk("full_count", 64'(o_fifo_count), 64'd16);
    chk("full_tready", 64'(o_axis_tready), 64'd0);
    chk("no_overflow_yet", 64'(o_overflow), 64'd0);
    cyc(1'b1, 32'hDEAD, 1'b0, 1'b0, 1'b0);
    chk("overflow_set", 64'(o_overflow), 64'd1);
    chk("full_count_hold", 64'(o_fifo_count), 64'd16);
    drain(1);
    chk("tready_reassert", 64'(o_axis_tready), 64'd1);
    chk("count_15", 64'(o_fifo_count), 64'd15);
    drain(15);
    chk("count_empty2", 64'(o_fifo_count), 64'd0);

    // Streaming through at count = 1; pointers wrap more than twice.
    cyc(1'b1, 32'h200, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 40; i++) begin
      cyc(1'b1, 32'h200 + 32'(i), 1'b1, 1'b0, 1'b1);
      chk("stream_count", 64'(o_fifo_count), 64'd1);
    end
    chk("stream_head", 64'(o_fifo_data), 64'h1_0000_0228);
    drain(1);

    // Read strobe while empty is ignored.
    cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    chk("ustb_count", 64'(o_fifo_count), 64'd0);
    chk("ustb_empty", 64'(o_fifo_empty), 64'd1);
    cyc(1'b1, 32'h77, 1'b1, 1'b1, 1'b0);
    chk("ustb_head", 64'(o_fifo_data), 64'h3_0000_0077);
    drain(1);

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'h300 + 32'(i), 1'b1, 1'b0, 1'b0);
    chk("pre_rst_count", 64'(o_fifo_count), 64'd5);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_count", 64'(o_fifo_count), 64'd0);
    chk("arst_not_empty", 64'(o_fifo_not_empty), 64'd0);
    chk("arst_empty", 64'(o_fifo_empty), 64'd1);
    chk("arst_overflow", 64'(o_overflow), 64'd0);
    chk("arst_tready", 64'(o_axis_tready), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(2);
    cyc(1'b1, 32'h55, 1'b1, 1'b0, 1'b0);
    chk("post_rst_head", 64'(o_fifo_data), 64'h1_0000_0055);
    chk("post_rst_not_empty", 64'(o_fifo_not_empty), 64'd1);
    drain(1);

`ifdef AXIS_FWFT_FIFO_PACKET_MODE_EN
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'h400 + 32'(i), 1'b0, 1'b0, 1'b0);
    chk("pkt_partial_held", 64'(o_fifo_not_empty), 64'd0);
    cyc(1'b1, 32'h404, 1'b1, 1'b0, 1'b0);
    chk("pkt_released", 64'(o_fifo_not_empty), 64'd1);
    drain(5);
    chk("pkt_drained", 64'(o_fifo_count), 64'd0);
    for (int i = 0; i < 16; i++) cyc(1'b1, 32'h500 + 32'(i), 1'b0, 1'b0, 1'b0);
    chk("pkt_escape", 64'(o_fifo_not_empty), 64'd1);
    chk("pkt_escape_head", 64'(o_fifo_data), 64'h0_0000_0500);
    rst = 1'b0;
    exp_q.delete();
    #1;
    rst = 1'b1;
    idle(1);
`endif

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
